branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Decode-stage branch/jump resolution unit; consumes the 4-bit sign/zero flag vector produced by the compare-to-zero comparator.
- Evaluates the MIPS branch/jump condition and computes the target.
- Registers a PC redirect toward the fetch stage and holds it until fetch accepts. Issues the link-register writeback request for AL-type and JAL/JALR.

Parameters:
- LINK_REG, 31, destination register for BGEZAL/BLTZAL/JAL.
- LINK_OFFSET, 8, byte offset added to the branch PC for the link value (PC of branch + delay slot).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  branch/jump instruction present in decode.
- id_ready  out  1  unit can accept; equals !pending.
- br_type  in  4  operation code, decoded in Behaviour.
- id_pc  in  32  PC of the branch instruction.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- cmp_flags  in  4  comparator output of rs_val: {gez, gtz, lez, ltz}, bit3..bit0.
- imm16  in  16  branch offset field.
- instr_index  in  26  J/JAL target field.
- rd_idx  in  5  JALR destination.
- flush  in  1  exception/eret flush from later stage.
- if_ready  in  1  fetch accepts redirect this cycle.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  new fetch PC.
- target_misalign  out  1  redirect_pc[1:0]!=0 on JR/JALR; valid with redirect_valid.
- link_we  out  1  one-cycle link writeback pulse.
- link_idx  out  5  link destination register.
- link_data  out  32  id_pc + LINK_OFFSET.

Behaviour:
- br_type encoding, shared package:
  - 0 NONE, 1 BEQ, 2 BNE, 3 BGEZ, 4 BGTZ, 5 BLEZ, 6 BLTZ, 7 BGEZAL, 8 BLTZAL, 9 J, 10 JAL, 11 JR, 12 JALR.
  - 13-15 behave as NONE.
- Conditions:
  - BEQ: rs_val==rt_val. BNE: rs_val!=rt_val.
  - BGEZ/BGEZAL: cmp_flags[3]. BGTZ: cmp_flags[2]. BLEZ: cmp_flags[1]. BLTZ/BLTZAL: cmp_flags[0].
  - J/JAL/JR/JALR: always taken.
- Targets, 32-bit modulo arithmetic with wrap-around and no overflow detection:
  - Branches: id_pc + 4 + (sign_extend(imm16) << 2).
  - J/JAL: {(id_pc+4)[31:28], instr_index, 2'b00}.
  - JR/JALR: rs_val, unmodified.
- Accept: accept = id_valid & id_ready & !flush.
- States: IDLE, PENDING.
- IDLE:
  - On accept of a taken op: latch redirect_pc, target_misalign; next state PENDING.
  - Not-taken op or NONE: stay IDLE, no redirect.
- PENDING:
  - redirect_valid=1; redirect_pc and target_misalign are stable.
  - id_ready=0.
  - Return to IDLE on the cycle after if_ready=1 is sampled.
- Latency: redirect_valid rises exactly 1 cycle after the accept edge. There is no combinational path from id inputs to redirect outputs.
- Link:
  - AL branches, JAL and JALR produce a link on accept whether taken or not. AL branches link even when not taken, per ISA.
  - link_we pulses for 1 cycle, 1 cycle after accept.
  - link_idx = LINK_REG, or rd_idx for JALR. link_data = id_pc + LINK_OFFSET.
  - JALR with rd_idx==0: link_we still pulses; the register file ignores r0.
- flush:
  - Highest priority: forces state IDLE and clears redirect_valid, target_misalign and link_we the next cycle.
  - flush in the same cycle as id_valid: no accept.
  - flush in the same cycle as if_ready while PENDING: IDLE, no further redirect.
- Reset: state IDLE; redirect_valid=0, redirect_pc=0, target_misalign=0, link_we=0, link_idx=0, link_data=0. id_ready=1 from the first cycle after reset.
- rst asserted mid-PENDING: identical to reset; the redirect is dropped.
- Ungated inputs: cmp_flags and operands are sampled only on accept; values in other cycles are don't-care.

Decomposition:
- Shared package/include: br_type localparams (BR_NONE..BR_JALR), state encodings, LINK_REG default.
- One natural sub-module: branch_target_calc, a combinational adder/concat producing the target and misalign flag. The condition mux and FSM stay in branch_resolve.

Test Plan:
- BEQ, rs=rt=0x5, imm16=0xFFFF, id_pc=0x1000, if_ready=1 → next cycle redirect_valid=1, redirect_pc=0x1000. IDLE the following cycle, id_ready=1.
- BGTZ, cmp_flags=4'b0010 (lez, since rs=0) → no redirect, id_ready stays 1. Same with cmp_flags=4'b1100 → redirect to id_pc+4+(imm<<2).
- BLTZAL not taken, id_pc=0x2000 → link_we pulse, link_idx=31, link_data=0x2008, redirect_valid=0.
- JR rs_val=0x00400002, if_ready=0 for 3 cycles → redirect_valid held 3+ cycles, redirect_pc stable, target_misalign=1, id_ready=0. A concurrent id_valid is not accepted.
- J at id_pc=0xBFC0_0010, instr_index=0x3FFFFFF → redirect_pc=0xBFFF_FFFC.
- flush asserted while PENDING and while id_valid=1, then rst mid-PENDING → redirect_valid=0 next cycle, no link_we; all outputs at reset values after rst.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the decode-stage branch resolution slice:
// operation codes, FSM states and link defaults.
package branch_resolve_pkg;

  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [3:0] BR_BEQ    = 4'd1;
  localparam logic [3:0] BR_BNE    = 4'd2;
  localparam logic [3:0] BR_BGEZ   = 4'd3;
  localparam logic [3:0] BR_BGTZ   = 4'd4;
  localparam logic [3:0] BR_BLEZ   = 4'd5;
  localparam logic [3:0] BR_BLTZ   = 4'd6;
  localparam logic [3:0] BR_BGEZAL = 4'd7;
  localparam logic [3:0] BR_BLTZAL = 4'd8;
  localparam logic [3:0] BR_J      = 4'd9;
  localparam logic [3:0] BR_JAL    = 4'd10;
  localparam logic [3:0] BR_JR     = 4'd11;
  localparam logic [3:0] BR_JALR   = 4'd12;

  localparam int LINK_REG_DEFAULT    = 31;
  localparam int LINK_OFFSET_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Ops that write a return address, whether or not the branch is taken.
  function automatic logic is_link_op(input logic [3:0] op);
    return (op == BR_BGEZAL) || (op == BR_BLTZAL) ||
           (op == BR_JAL)    || (op == BR_JALR);
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target generator: PC-relative branch adder, J-type
// region concat, or register target with an alignment check.
module branch_target_calc
  import branch_resolve_pkg::*;
(
  input  logic [3:0]  br_type,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs_val,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] pc_plus4;
  logic [31:0] imm_offset;

  // Select the target form by operation class; only register jumps can misalign.
  always_comb begin
    pc_plus4   = id_pc + 32'd4;
    imm_offset = {{14{imm16[15]}}, imm16, 2'b00};
    target     = pc_plus4 + imm_offset;
    misalign   = 1'b0;
    case (br_type)
      BR_J, BR_JAL: target = {pc_plus4[31:28], instr_index, 2'b00};
      BR_JR, BR_JALR: begin
        target   = rs_val;
        misalign = (rs_val[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Decode-stage branch/jump resolution: evaluates the condition, holds a
// registered redirect until fetch accepts it, and pulses the link write.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int LINK_REG    = LINK_REG_DEFAULT,
  parameter int LINK_OFFSET = LINK_OFFSET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  br_type,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [3:0]  cmp_flags,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [4:0]  rd_idx,
  input  logic        flush,
  input  logic        if_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        target_misalign,
  output logic        link_we,
  output logic [4:0]  link_idx,
  output logic [31:0] link_data
);

  localparam logic [4:0]  LINK_IDX = 5'(LINK_REG);
  localparam logic [31:0] LINK_OFF = 32'(LINK_OFFSET);

  state_t      state, next_state;
  logic        taken;
  logic        accept;
  logic        link_op;
  logic        release_redirect;
  logic [31:0] target;
  logic        misalign;

  branch_target_calc u_target (
    .br_type     (br_type),
    .id_pc       (id_pc),
    .rs_val      (rs_val),
    .imm16       (imm16),
    .instr_index (instr_index),
    .target      (target),
    .misalign    (misalign)
  );

  assign redirect_valid   = (state == ST_PENDING);
  assign id_ready         = !redirect_valid;
  assign accept           = id_valid && id_ready && !flush;
  assign link_op          = is_link_op(br_type);
  assign release_redirect = redirect_valid && (flush || if_ready);

  // Branch condition mux over operand equality and the comparator flags.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:                          taken = (rs_val == rt_val);
      BR_BNE:                          taken = (rs_val != rt_val);
      BR_BGEZ, BR_BGEZAL:              taken = cmp_flags[3];
      BR_BGTZ:                         taken = cmp_flags[2];
      BR_BLEZ:                         taken = cmp_flags[1];
      BR_BLTZ, BR_BLTZAL:              taken = cmp_flags[0];
      BR_J, BR_JAL, BR_JR, BR_JALR:    taken = 1'b1;
      default:                         taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Enter PENDING on a taken accept; leave once fetch takes it or on flush.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept && taken) next_state = ST_PENDING;
      ST_PENDING: if (flush || if_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Redirect payload and link writeback registers, captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc     <= '0;
      target_misalign <= 1'b0;
      link_we         <= 1'b0;
      link_idx        <= '0;
      link_data       <= '0;
    end else begin
      link_we <= accept && link_op;
      if (accept && link_op) begin
        link_idx  <= (br_type == BR_JALR) ? rd_idx : LINK_IDX;
        link_data <= id_pc + LINK_OFF;
      end
      if (accept && taken) begin
        redirect_pc     <= target;
        target_misalign <= misalign;
      end else if (release_redirect) begin
        target_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  br_type;
  logic [31:0] id_pc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  cmp_flags;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [4:0]  rd_idx;
  logic        flush;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        target_misalign;
  logic        link_we;
  logic [4:0]  link_idx;
  logic [31:0] link_data;

  int checks   = 0;
  int failures = 0;

  // Model state: what fetch and the register file should currently see.
  bit          m_pending;
  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_link_we;
  logic [4:0]  m_link_idx;
  logic [31:0] m_link_data;

  branch_resolve dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .br_type         (br_type),
    .id_pc           (id_pc),
    .rs_val          (rs_val),
    .rt_val          (rt_val),
    .cmp_flags       (cmp_flags),
    .imm16           (imm16),
    .instr_index     (instr_index),
    .rd_idx          (rd_idx),
    .flush           (flush),
    .if_ready        (if_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .target_misalign (target_misalign),
    .link_we         (link_we),
    .link_idx        (link_idx),
    .link_data       (link_data)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit modelTaken(input logic [3:0] t, input logic [31:0] rs,
                                    input logic [31:0] rt, input logic [3:0] f);
    case (t)
      4'd1:               return rs == rt;
      4'd2:               return rs != rt;
      4'd3, 4'd7:         return f[3];
      4'd4:               return f[2];
      4'd5:               return f[1];
      4'd6, 4'd8:         return f[0];
      4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelTarget(input logic [3:0] t, input logic [31:0] pc,
                                              input logic [31:0] rs, input logic [15:0] imm,
                                              input logic [25:0] idx);
    logic [31:0] off;
    logic [31:0] region;
    off    = {{16{imm[15]}}, imm};
    region = (pc + 32'd4) & 32'hF000_0000;
    if (t == 4'd9 || t == 4'd10) return region | ({6'd0, idx} * 32'd4);
    if (t == 4'd11 || t == 4'd12) return rs;
    return pc + 32'd4 + off * 32'd4;
  endfunction

  // Reference model advances on every rising edge from the sampled inputs.
  always @(posedge clk) begin
    bit acc;
    bit lnk;
    if (rst) begin
      m_pending = 0; m_pc = 0; m_mis = 0;
      m_link_we = 0; m_link_idx = 0; m_link_data = 0;
    end else begin
      acc = id_valid && !m_pending && !flush;
      lnk = acc && (br_type == 4'd7 || br_type == 4'd8 || br_type == 4'd10 || br_type == 4'd12);
      if (m_pending) begin
        if (flush || if_ready) begin
          m_pending = 0;
          m_mis     = 0;
        end
      end else if (acc && modelTaken(br_type, rs_val, rt_val, cmp_flags)) begin
        m_pending = 1;
        m_pc      = modelTarget(br_type, id_pc, rs_val, imm16, instr_index);
        m_mis     = (br_type == 4'd11 || br_type == 4'd12) && (m_pc % 4 != 0);
      end
      m_link_we = lnk;
      if (lnk) begin
        m_link_idx  = (br_type == 4'd12) ? rd_idx : 5'd31;
        m_link_data = id_pc + 32'd8;
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("redirect_valid", 32'(redirect_valid), 32'(m_pending));
    checkValue("id_ready", 32'(id_ready), 32'(!m_pending));
    checkValue("target_misalign", 32'(target_misalign), 32'(m_mis));
    checkValue("link_we", 32'(link_we), 32'(m_link_we));
    if (m_pending) checkValue("redirect_pc", redirect_pc, m_pc);
    if (m_link_we) begin
      checkValue("link_idx", 32'(link_idx), 32'(m_link_idx));
      checkValue("link_data", link_data, m_link_data);
    end
  endtask

  // Compare process: outputs checked shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [3:0] t, input logic [31:0] pc,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [3:0] f, input logic [15:0] imm,
                               input logic [25:0] idx, input logic [4:0] rd,
                               input logic fl, input logic ifr, input logic r);
    @(negedge clk);
    id_valid = v; br_type = t; id_pc = pc; rs_val = rs; rt_val = rt;
    cmp_flags = f; imm16 = imm; instr_index = idx; rd_idx = rd;
    flush = fl; if_ready = ifr; rst = r;
  endtask

  task automatic applyIdle(input logic fl, input logic ifr);
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 4'h0, 16'h0, 26'h0, 5'h0, fl, ifr, 1'b0);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetValues(input string tag);
    checkValue({tag, "_rv"}, 32'(redirect_valid), 32'd0);
    checkValue({tag, "_rpc"}, redirect_pc, 32'd0);
    checkValue({tag, "_mis"}, 32'(target_misalign), 32'd0);
    checkValue({tag, "_lwe"}, 32'(link_we), 32'd0);
    checkValue({tag, "_lidx"}, 32'(link_idx), 32'd0);
    checkValue({tag, "_ldata"}, link_data, 32'd0);
    checkValue({tag, "_rdy"}, 32'(id_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rs;
    logic [3:0]  t;
    rst = 1'b1; id_valid = 0; br_type = 0; id_pc = 0; rs_val = 0; rt_val = 0;
    cmp_flags = 0; imm16 = 0; instr_index = 0; rd_idx = 0; flush = 0; if_ready = 0;
    repeat (2) @(posedge clk);
    applyIdle(1'b0, 1'b0);
    afterEdge();
    checkResetValues("reset");

    // BEQ taken back to its own PC.
    applyStimulus(1, 4'd1, 32'h1000, 32'h5, 32'h5, 4'b1100, 16'hFFFF, 26'h0, 5'd0, 0, 1, 0);
    afterEdge();
    checkValue("beq_rv", 32'(redirect_valid), 32'd1);
    checkValue("beq_rpc", redirect_pc, 32'h1000);
    applyIdle(1'b0, 1'b1);
    afterEdge();
    checkValue("beq_release_rv", 32'(redirect_valid), 32'd0);
    checkValue("beq_release_rdy", 32'(id_ready), 32'd1);

    // BGTZ not taken, then taken.
    applyStimulus(1, 4'd4, 32'h3000, 32'h0, 32'h0, 4'b0010, 16'h0004, 26'h0, 5'd0, 0, 1, 0);
    afterEdge();
    checkValue("bgtz_nt_rv", 32'(redirect_valid), 32'd0);
    checkValue("bgtz_nt_rdy", 32'(id_ready), 32'd1);
    applyStimulus(1, 4'd4, 32'h3000, 32'h7, 32'h0, 4'b1100, 16'h0004, 26'h0, 5'd0, 0, 1, 0);
    afterEdge();
    checkValue("bgtz_t_rpc", redirect_pc, 32'h3014);
    applyIdle(1'b0, 1'b1);

    // BLTZAL not taken still links.
    applyStimulus(1, 4'd8, 32'h2000, 32'h1, 32'h0, 4'b1100, 16'h0010, 26'h0, 5'd0, 0, 1, 0);
    afterEdge();
    checkValue("bltzal_lwe", 32'(link_we), 32'd1);
    checkValue("bltzal_lidx", 32'(link_idx), 32'd31);
    checkValue("bltzal_ldata", link_data, 32'h2008);
    checkValue("bltzal_rv", 32'(redirect_valid), 32'd0);
    applyIdle(1'b0, 1'b0);
    afterEdge();
    checkValue("bltzal_pulse_end", 32'(link_we), 32'd0);

    // JR misaligned, held while fetch stalls; JAL offered meanwhile is refused.
    applyStimulus(1, 4'd11, 32'h500, 32'h0040_0002, 32'h0, 4'b1100, 16'h0, 26'h0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      afterEdge();
      checkValue("jr_rv_held", 32'(redirect_valid), 32'd1);
      checkValue("jr_rpc_held", redirect_pc, 32'h0040_0002);
      checkValue("jr_mis", 32'(target_misalign), 32'd1);
      checkValue("jr_rdy", 32'(id_ready), 32'd0);
      if (i > 0) checkValue("jr_no_link", 32'(link_we), 32'd0);
      applyStimulus(1, 4'd10, 32'h600, 32'h0, 32'h0, 4'h0, 16'h0, 26'h123, 5'd0, 0, 0, 0);
    end
    afterEdge();
    checkValue("jr_still_held", redirect_pc, 32'h0040_0002);
    checkValue("jr_refused_link", 32'(link_we), 32'd0);
    applyIdle(1'b0, 1'b1);
    afterEdge();
    checkValue("jr_released", 32'(redirect_valid), 32'd0);

    // J at top of a region.
    applyStimulus(1, 4'd9, 32'hBFC0_0010, 32'h0, 32'h0, 4'h0, 16'h0, 26'h3FF_FFFF, 5'd0, 0, 0, 0);
    afterEdge();
    checkValue("j_rpc", redirect_pc, 32'hBFFF_FFFC);
    checkValue("j_mis", 32'(target_misalign), 32'd0);

    // Flush while pending drops the redirect.
    applyIdle(1'b1, 1'b0);
    afterEdge();
    checkValue("flush_pend_rv", 32'(redirect_valid), 32'd0);
    // Flush alongside a valid JAL: no accept, no link.
    applyStimulus(1, 4'd10, 32'h700, 32'h0, 32'h0, 4'h0, 16'h0, 26'h10, 5'd0, 1, 0, 0);
    afterEdge();
    checkValue("flush_id_rv", 32'(redirect_valid), 32'd0);
    checkValue("flush_id_lwe", 32'(link_we), 32'd0);

    // JALR to r0, then reset in the middle of the pending redirect.
    applyStimulus(1, 4'd12, 32'h800, 32'h0000_0101, 32'h0, 4'h0, 16'h0, 26'h0, 5'd0, 0, 0, 0);
    afterEdge();
    checkValue("jalr_r0_lwe", 32'(link_we), 32'd1);
    checkValue("jalr_r0_lidx", 32'(link_idx), 32'd0);
    checkValue("jalr_mis", 32'(target_misalign), 32'd1);
    applyStimulus(1, 4'd10, 32'h900, 32'h0, 32'h0, 4'h0, 16'h0, 26'h0, 5'd0, 0, 0, 1);
    afterEdge();
    checkResetValues("midrst");

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      t  = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      applyStimulus(logic'($urandom_range(0, 9) < 6), t, $urandom, rs,
                    ($urandom_range(0, 2) == 0) ? rs : $urandom,
                    ($urandom_range(0, 4) == 0) ? 4'($urandom) :
                      {!rs[31], !rs[31] && rs != 0, rs[31] || rs == 0, rs[31]},
                    16'($urandom), 26'($urandom), 5'($urandom),
                    logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 99) == 0));
    end
    applyIdle(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
